alu_seq: RTL and testbench

Parametrised multi-cycle ALU, successor to the combinational 32-bit ALU, with the same operand/select/result/overflow port set plus a start/busy/done handshake. Single-cycle ops complete in one clock; multiply runs an iterative shift-add over WIDTH clocks instead of a combinational multiplier. Sits between the operand register file and the writeback stage of the datapath. All outputs are registered.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 79 +++++++
 rtl/alu_seq.sv | 142 ++++++++++++++
 tb/tb_alu_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and width helper for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_AND = 1;
  localparam int unsigned OP_EQ  = 2;
  localparam int unsigned OP_GT  = 3;
  localparam int unsigned OP_SHL = 4;
  localparam int unsigned OP_SHR = 5;
  localparam int unsigned OP_MUL = 6;
  localparam int unsigned OP_SUB = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; used for shift-amount and iteration-counter widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock over WIDTH clocks.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH);

  logic              busy_q,   busy_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [PW-1:0]     acc_q,    acc_d;
  logic [PW-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     step_sum;
  logic              last_step;

  // p is the accumulator including the current step, so the final product is
  // visible in the same cycle as done and the parent can register it on that edge.
  assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign p         = step_sum;
  assign done      = last_step;
  assign busy      = busy_q;

  // Next-state: load operands on start, otherwise add-and-shift while busy.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (last_step) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake; MUL runs on the iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  alu_s;
  logic              alu_ovf;
  logic [SHW-1:0]    shamt;
  logic              is_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [PW-1:0]     mul_p;

  assign shamt     = b[SHW-1:0];
  assign is_mul    = (32'(sel) == OP_MUL);
  assign mul_start = (state_q == IDLE) && start && is_mul;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Single-cycle operations, evaluated in front of the result register.
  always_comb begin
    alu_s   = '0;
    alu_ovf = 1'b0;
    case (32'(sel))
      OP_ADD: {alu_ovf, alu_s} = {1'b0, a} + {1'b0, b};
      OP_AND: alu_s = a & b;
      OP_EQ:  alu_s[0] = (a == b);
      OP_GT:  alu_s[0] = (a > b);
      OP_SHL: alu_s = a << shamt;
      OP_SHR: alu_s = a >> shamt;
      OP_SUB: begin
        alu_s   = a - b;
        alu_ovf = (a < b);
      end
      default: begin
        alu_s   = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Control FSM next-state; result/flag only change on the transition into DONE.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (is_mul) begin
            state_d = MUL;
          end else begin
            state_d = DONE;
            s_d     = alu_s;
            ovf_d   = alu_ovf;
            done_d  = 1'b1;
          end
        end
      end
      MUL: begin
        if (!mul_busy) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (mul_done) begin
          state_d = DONE;
          s_d     = mul_p[WIDTH-1:0];
          ovf_d   = |mul_p[PW-1:WIDTH];
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s        = s_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  sel = '0;
  logic [31:0] s;
  logic        overflow, busy, done;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [4:0]  sel8 = '0;
  logic [7:0]  s8;
  logic        overflow8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SEL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sel(sel),
    .s(s), .overflow(overflow), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8), .SEL_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .sel(sel8),
    .s(s8), .overflow(overflow8), .busy(busy8), .done(done8)
  );

  // Reference model using wide arithmetic.
  function automatic exp_t model(input int w, input int op, input logic [63:0] ai, input logic [63:0] bi);
    exp_t r;
    logic [63:0] m, x, y, t;
    int sh;
    m = (64'd1 << w) - 64'd1;
    x = ai & m;
    y = bi & m;
    sh = int'(y & 64'(w - 1));
    r.s = '0; r.ovf = 1'b0; r.lat = 1;
    t = '0;
    case (op)
      0: begin t = x + y; r.s = 32'(t & m); r.ovf = ((t >> w) != 0); end
      1: r.s = 32'(x & y);
      2: r.s = (x == y) ? 32'd1 : 32'd0;
      3: r.s = (x > y) ? 32'd1 : 32'd0;
      4: r.s = 32'((x << sh) & m);
      5: r.s = 32'(x >> sh);
      6: begin t = x * y; r.s = 32'(t & m); r.ovf = ((t >> w) != 0); r.lat = w + 1; end
      7: begin r.s = 32'((x - y) & m); r.ovf = (x < y); end
      default: ;
    endcase
    return r;
  endfunction

  // Drives one request and records what the DUT produces (no checking here).
  task automatic run_op(input int which, input int op, input logic [31:0] ai, input logic [31:0] bi,
                        output int lat, output logic [31:0] so, output logic ovfo,
                        output int ndone, output logic busy_after);
    logic d;
    lat = -1; ndone = 0; so = '0; ovfo = 1'b0; busy_after = 1'b1;
    if (which == 0) begin
      start = 1'b1; sel = 5'(op); a = ai; b = bi;
    end else begin
      start8 = 1'b1; sel8 = 5'(op); a8 = ai[7:0]; b8 = bi[7:0];
    end
    @(posedge clk);
    #1;
    start = 1'b0; start8 = 1'b0;
    a = $urandom; b = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      d = (which == 0) ? done : done8;
      if (d) begin
        ndone++;
        if (lat < 0) begin
          lat  = c;
          so   = (which == 0) ? s : {24'b0, s8};
          ovfo = (which == 0) ? overflow : overflow8;
        end
      end
      if (lat > 0 && c == lat + 1) begin
        busy_after = (which == 0) ? busy : busy8;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1; sel = 5'd0; a = 32'd1; b = 32'd1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s, overflow, busy, done} !== 35'd0) begin
      n_fail++; $display("FAIL reset32 got s=%h ovf=%b busy=%b done=%b want all 0", s, overflow, busy, done);
    end
    n_checks++;
    if ({s8, overflow8, busy8, done8} !== 11'd0) begin
      n_fail++; $display("FAIL reset8 got s=%h ovf=%b busy=%b done=%b want all 0", s8, overflow8, busy8, done8);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_lost got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    logic [31:0] ta[2] = '{32'd4, 32'hFFFF_FFFF};
    logic [31:0] tb[2] = '{32'd6, 32'd1};
    int lat, nd; logic [31:0] so; logic ov, ba; exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(32, 0, 64'(ta[i]), 64'(tb[i])));
      run_op(0, 0, ta[i], tb[i], lat, so, ov, nd, ba);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || nd !== 1) begin
        n_fail++; $display("FAIL add_latency[%0d] got lat=%0d dones=%0d want lat=%0d dones=1", i, lat, nd, e.lat);
      end
      n_checks++;
      if (so !== e.s || ov !== e.ovf) begin
        n_fail++; $display("FAIL add_result[%0d] got s=%h ovf=%b want s=%h ovf=%b", i, so, ov, e.s, e.ovf);
      end
      n_checks++;
      if (ba !== 1'b0) begin
        n_fail++; $display("FAIL add_busy_c2[%0d] got busy=%b want 0", i, ba);
      end
    end
  endtask

  task automatic test_mul;
    logic [31:0] ta[4] = '{32'd4, 32'h0001_0000, 32'd12345, 32'hDEAD_BEEF};
    logic [31:0] tb[4] = '{32'd6, 32'h0001_0000, 32'd0,     32'h0000_0003};
    int lat, nd; logic [31:0] so; logic ov, ba; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(32, 6, 64'(ta[i]), 64'(tb[i])));
      run_op(0, 6, ta[i], tb[i], lat, so, ov, nd, ba);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || nd !== 1 || ba !== 1'b0) begin
        n_fail++; $display("FAIL mul_timing[%0d] got lat=%0d dones=%0d busy_after=%b want lat=%0d dones=1 busy_after=0", i, lat, nd, ba, e.lat);
      end
      n_checks++;
      if (so !== e.s || ov !== e.ovf) begin
        n_fail++; $display("FAIL mul_result[%0d] got s=%h ovf=%b want s=%h ovf=%b", i, so, ov, e.s, e.ovf);
      end
    end
  endtask

  task automatic test_single_ops;
    int          top[9] = '{4, 5, 2, 3, 7, 1, 20, 31, 8};
    logic [31:0] ta[9] = '{32'd4, 32'h8000_0000, 32'd6, 32'd4, 32'd4, 32'hF0F0_1234, 32'd9, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] tb[9] = '{32'd35, 32'd31, 32'd6, 32'd6, 32'd6, 32'h0FF0_FF00, 32'd9, 32'hFFFF_FFFF, 32'd7};
    int lat, nd; logic [31:0] so, ra, rb; logic ov, ba; exp_t e; int op;
    for (int i = 0; i < 9 + 16; i++) begin
      if (i < 9) begin
        op = top[i]; ra = ta[i]; rb = tb[i];
      end else begin
        op = int'($urandom_range(0, 8)); ra = $urandom; rb = $urandom;
        if (op == 6) op = 0;
        if (i % 4 == 0) rb = ra;
      end
      sb.push_back(model(32, op, 64'(ra), 64'(rb)));
      run_op(0, op, ra, rb, lat, so, ov, nd, ba);
      e = sb.pop_front();
      n_checks++;
      if (lat !== 1 || nd !== 1 || ba !== 1'b0 || so !== e.s || ov !== e.ovf) begin
        n_fail++; $display("FAIL op%0d[%0d] a=%h b=%h got s=%h ovf=%b lat=%0d dones=%0d want s=%h ovf=%b lat=1 dones=1",
                           op, i, ra, rb, so, ov, lat, nd, e.s, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, nd; logic [31:0] so; logic ov, ba; exp_t e;
    sb.push_back(model(32, 0, 64'd100, 64'd23));
    sb.push_back(model(32, 7, 64'd5, 64'd9));
    sb.push_back(model(32, 6, 64'd7, 64'd11));
    sb.push_back(model(32, 1, 64'hFF, 64'h0F));
    run_op(0, 0, 32'd100, 32'd23, lat, so, ov, nd, ba);
    e = sb.pop_front(); n_checks++;
    if (so !== e.s || ov !== e.ovf || lat !== e.lat) begin n_fail++; $display("FAIL b2b_0 got s=%h ovf=%b lat=%0d want s=%h ovf=%b lat=%0d", so, ov, lat, e.s, e.ovf, e.lat); end
    run_op(0, 7, 32'd5, 32'd9, lat, so, ov, nd, ba);
    e = sb.pop_front(); n_checks++;
    if (so !== e.s || ov !== e.ovf || lat !== e.lat) begin n_fail++; $display("FAIL b2b_1 got s=%h ovf=%b lat=%0d want s=%h ovf=%b lat=%0d", so, ov, lat, e.s, e.ovf, e.lat); end
    run_op(0, 6, 32'd7, 32'd11, lat, so, ov, nd, ba);
    e = sb.pop_front(); n_checks++;
    if (so !== e.s || ov !== e.ovf || lat !== e.lat) begin n_fail++; $display("FAIL b2b_2 got s=%h ovf=%b lat=%0d want s=%h ovf=%b lat=%0d", so, ov, lat, e.s, e.ovf, e.lat); end
    run_op(0, 1, 32'hFF, 32'h0F, lat, so, ov, nd, ba);
    e = sb.pop_front(); n_checks++;
    if (so !== e.s || ov !== e.ovf || lat !== e.lat) begin n_fail++; $display("FAIL b2b_3 got s=%h ovf=%b lat=%0d want s=%h ovf=%b lat=%0d", so, ov, lat, e.s, e.ovf, e.lat); end
  endtask

  task automatic test_start_while_busy;
    int first, nd; logic [31:0] so; logic ov; exp_t e;
    first = -1; nd = 0; so = '0; ov = 1'b0;
    sb.push_back(model(32, 6, 64'd4, 64'd6));
    start = 1'b1; sel = 5'd6; a = 32'd4; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin first = c; so = s; ov = overflow; end
      end
      if (c == 5) begin start = 1'b1; sel = 5'd0; a = 32'd2; b = 32'd3; end
      if (c == 6) start = 1'b0;
    end
    e = sb.pop_front();
    n_checks++;
    if (first !== e.lat || nd !== 1) begin
      n_fail++; $display("FAIL busy_start_timing got first_done=%0d dones=%0d want %0d and 1", first, nd, e.lat);
    end
    n_checks++;
    if (so !== e.s || ov !== e.ovf) begin
      n_fail++; $display("FAIL busy_start_result got s=%h ovf=%b want s=%h ovf=%b", so, ov, e.s, e.ovf);
    end
  endtask

  task automatic test_reset_mid_mul;
    int nd, lat; logic [31:0] so; logic ov, ba, zero_ok; exp_t e;
    nd = 0; zero_ok = 1'b1;
    start = 1'b1; sel = 5'd6; a = 32'd4; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (c >= 11 && {s, overflow, busy, done} !== 35'd0) zero_ok = 1'b0;
      if (c == 10) rst_n = 1'b0;
      if (c == 11) rst_n = 1'b1;
    end
    n_checks++;
    if (zero_ok !== 1'b1 || nd !== 0) begin
      n_fail++; $display("FAIL mid_mul_reset got outputs_zero=%b dones=%0d want 1 and 0", zero_ok, nd);
    end
    sb.push_back(model(32, 0, 64'd2, 64'd3));
    run_op(0, 0, 32'd2, 32'd3, lat, so, ov, nd, ba);
    e = sb.pop_front();
    n_checks++;
    if (so !== e.s || ov !== e.ovf || lat !== e.lat || nd !== 1) begin
      n_fail++; $display("FAIL post_reset_add got s=%h ovf=%b lat=%0d dones=%0d want s=%h ovf=%b lat=%0d dones=1", so, ov, lat, nd, e.s, e.ovf, e.lat);
    end
  endtask

  task automatic test_width8;
    int          top[5] = '{6, 6, 0, 4, 20};
    logic [31:0] ta[5] = '{32'd16, 32'd13, 32'd200, 32'd3, 32'd5};
    logic [31:0] tb[5] = '{32'd16, 32'd11, 32'd100, 32'd13, 32'd5};
    int lat, nd; logic [31:0] so; logic ov, ba; exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(model(8, top[i], 64'(ta[i]), 64'(tb[i])));
      run_op(1, top[i], ta[i], tb[i], lat, so, ov, nd, ba);
      e = sb.pop_front();
      n_checks++;
      if (lat !== e.lat || nd !== 1 || ba !== 1'b0 || so !== e.s || ov !== e.ovf) begin
        n_fail++; $display("FAIL w8_op%0d[%0d] got s=%h ovf=%b lat=%0d dones=%0d want s=%h ovf=%b lat=%0d dones=1",
                           top[i], i, so, ov, lat, nd, e.s, e.ovf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_single_ops();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_mul();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
